// File: rtl/riscv_pkg.sv
// riscv_pkg: register-file geometry and dump-engine state encoding shared across the core.
package riscv_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    typedef enum logic [1:0] {DUMP_IDLE, DUMP_RUN, DUMP_DONE} dump_state_t;
endpackage

// File: rtl/stream_out_reg.sv
// stream_out_reg: one-entry valid/ready output register; reports when it accepts a new payload.
module stream_out_reg
    import riscv_pkg::*;
#(
    parameter int W = XLEN + REG_ADDR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         avail,
    input  logic [W-1:0] d,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] q,
    output logic         load
);
    assign load = avail && (!valid || ready);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks the register file through a spare read port and
// streams (address, data) beats on a valid/ready interface.
module regfile_dump_reader
    import riscv_pkg::*;
#(
    parameter int DATA_W   = riscv_pkg::XLEN,
    parameter int ADDR_W   = riscv_pkg::REG_ADDR_W,
    parameter int NUM_REGS = riscv_pkg::NUM_REGS,
    parameter int SKIP_X0  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rd_adr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_adr,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              done
);
    localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(SKIP_X0 != 0);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);
    dump_state_t state;
    logic [ADDR_W-1:0] ptr;
    logic issued_all, load, flush, hs, avail;
    logic [ADDR_W+DATA_W-1:0] payload;
    assign flush  = abort && state != DUMP_IDLE;
    assign avail  = state == DUMP_RUN && !issued_all && !flush;
    assign hs     = m_valid && m_ready;
    assign rd_adr = ptr;
    assign m_adr  = payload[ADDR_W+DATA_W-1:DATA_W];
    assign m_data = payload[DATA_W-1:0];
    // rd_data is captured in the same cycle ptr addresses it, so a concurrent write lands after
    stream_out_reg #(.W(ADDR_W + DATA_W)) u_out (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .avail (avail),
        .d     ({ptr, rd_data}),
        .ready (m_ready),
        .valid (m_valid),
        .q     (payload),
        .load  (load)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DUMP_IDLE;
            ptr        <= FIRST;
            issued_all <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (flush) begin
            state      <= DUMP_IDLE;
            ptr        <= FIRST;
            issued_all <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                DUMP_IDLE: if (start) begin
                    state      <= DUMP_RUN;
                    ptr        <= FIRST;
                    issued_all <= 1'b0;
                    busy       <= 1'b1;
                end
                DUMP_RUN: begin
                    if (load) begin
                        if (ptr == LAST) issued_all <= 1'b1;
                        else ptr <= ptr + 1'b1;
                    end
                    if (issued_all && (!m_valid || hs)) begin
                        state <= DUMP_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DUMP_DONE: begin
                    state      <= DUMP_IDLE;
                    ptr        <= FIRST;
                    issued_all <= 1'b0;
                    done       <= 1'b0;
                end
                default: state <= DUMP_IDLE;
            endcase
        end
    end
endmodule
